aes_encrypt_core: RTL and testbench



---
 rtl/aes_encrypt_core_if.sv | 12 +
 rtl/aes_encrypt_core.sv | 150 +++++++++++++++
 tb/tb_aes_encrypt_core.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_encrypt_core_if.sv
// Start/ready bus for the iterative AES encryption core: block, key and size
// select in, registered result and ready flag out.
interface aes_encrypt_core_if;
   logic [127:0] plaintext;
   logic [255:0] key;
   logic [2:0]   key_len;
   logic [127:0] ciphertext;
   logic         ready;

   modport master (output plaintext, key, key_len, input ciphertext, ready);
   modport slave  (input plaintext, key, key_len, output ciphertext, ready);
endinterface

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128/192/256 encryption: expands the key one word per clock,
// then runs one cipher round per clock from a 60-word key store.
//
//  state  | meaning
//  IDLE   | result held, waiting for nonzero key_len to start
//  EXPAND | key schedule, one word w[i] per cycle
//  ROUND  | one cipher round per cycle, last round skips MixColumns
module aes_encrypt_core (
   input logic clk,
   input logic reset,
   aes_encrypt_core_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXPAND, ROUND} fsm_t;

   // FIPS-197 S-box, entry 0x00 in the top byte
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   // SubBytes and ShiftRows fused: byte (row rr, col c) comes from col c+rr
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int rr = 0; rr < 4; rr++)
            o[127-8*(4*c+rr) -: 8] = sbox(s[127-8*(4*((c+rr)%4)+rr) -: 8]);
      return o;
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] a);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = a;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
      return o;
   endfunction

   fsm_t         fsm;
   logic [31:0]  w [60];
   logic [127:0] blk;
   logic [3:0]   nk, nr, r;
   logic [5:0]   widx, last_idx;
   logic [2:0]   mod_cnt;
   logic [7:0]   rcon;

   logic [31:0]  prev_word, temp_word;
   logic [5:0]   rk_base;
   logic [127:0] round_key, shifted, round_out, key_head;

   always_comb begin
      prev_word = w[widx - 6'd1];
      if (mod_cnt == 3'd0)
         temp_word = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon, 24'h0};
      else if (nk == 4'd8 && mod_cnt == 3'd4)
         temp_word = sub_word(prev_word);
      else
         temp_word = prev_word;
      rk_base   = {r, 2'b00};
      round_key = {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};
      shifted   = sub_shift(blk);
      round_out = ((r == nr) ? shifted : mix_columns(shifted)) ^ round_key;
      if (bus.key_len[2])
         key_head = bus.key[255:128];
      else if (bus.key_len[1])
         key_head = bus.key[191:64];
      else
         key_head = bus.key[127:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm            <= IDLE;
         bus.ready      <= 1'b0;
         bus.ciphertext <= '0;
      end else begin
         case (fsm)
            IDLE: begin
               if (bus.key_len != 3'b000) begin
                  if (bus.key_len[2]) begin
                     nk <= 4'd8; nr <= 4'd14; last_idx <= 6'd59; widx <= 6'd8;
                     for (int j = 0; j < 8; j++) w[j] <= bus.key[255-32*j -: 32];
                  end else if (bus.key_len[1]) begin
                     nk <= 4'd6; nr <= 4'd12; last_idx <= 6'd51; widx <= 6'd6;
                     for (int j = 0; j < 6; j++) w[j] <= bus.key[191-32*j -: 32];
                  end else begin
                     nk <= 4'd4; nr <= 4'd10; last_idx <= 6'd43; widx <= 6'd4;
                     for (int j = 0; j < 4; j++) w[j] <= bus.key[127-32*j -: 32];
                  end
                  blk       <= bus.plaintext ^ key_head;
                  mod_cnt   <= 3'd0;
                  rcon      <= 8'h01;
                  bus.ready <= 1'b0;
                  fsm       <= EXPAND;
               end
            end
            EXPAND: begin
               w[widx] <= w[widx - {2'b00, nk}] ^ temp_word;
               if ({1'b0, mod_cnt} == nk - 4'd1)
                  mod_cnt <= 3'd0;
               else
                  mod_cnt <= mod_cnt + 3'd1;
               if (mod_cnt == 3'd0)
                  rcon <= xtime(rcon);
               widx <= widx + 6'd1;
               if (widx == last_idx) begin
                  r   <= 4'd1;
                  fsm <= ROUND;
               end
            end
            ROUND: begin
               blk <= round_out;
               r   <= r + 4'd1;
               if (r == nr) begin
                  bus.ciphertext <= round_out;
                  bus.ready      <= 1'b1;
                  fsm            <= IDLE;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_encrypt_core.sv
// Bench for aes_encrypt_core: byte-level AES reference with a field-arithmetic
// S-box, a cycle-level start/complete model, and FIPS-197 literal vectors.
module tb_aes_encrypt_core;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   aes_encrypt_core_if bus ();
   aes_encrypt_core dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   logic [7:0] sb [256];

   localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] K128   = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
   localparam logic [255:0] K192   = {64'h0, 192'h000102030405060708090a0b0c0d0e0f1011121314151617};
   localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] PT_ALT = 128'hdeadbeef0123456789abcdeffedcba98;
   localparam logic [255:0] K_ALT  = 256'hfedcba9876543210_0f1e2d3c4b5a6978_2b7e151628aed2a6_abf7158809cf4f3c;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = xt(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic int nk_of(input logic [2:0] kl);
      return kl[2] ? 8 : (kl[1] ? 6 : 4);
   endfunction

   function automatic int lat_of(input int nk);
      int nr = nk + 6;
      return 4 * (nr + 1) - nk + nr;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] x);
      return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
   endfunction

   function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [255:0] k, input int nk);
      logic [31:0]  w [60];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [31:0]  tmp;
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [127:0] o;
      int nr = nk + 6;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = k[32*(nk-1-i) +: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         tmp = w[i-1];
         if (i % nk == 0) begin
            tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
            rc  = xt(rc);
         end else if (nk == 8 && i % 8 == 4) begin
            tmp = subw(tmp);
         end
         w[i] = w[i-nk] ^ tmp;
      end
      for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
      for (int rnd = 1; rnd <= nr; rnd++) begin
         for (int j = 0; j < 16; j++) t[j] = sb[s[j]];
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) s[rr+4*c] = t[rr+4*((c+rr)%4)];
         if (rnd < nr) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
               s[4*c+3] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
            end
         end
         for (int j = 0; j < 16; j++) s[j] ^= w[4*rnd + j/4][31-8*(j%4) -: 8];
      end
      for (int j = 0; j < 16; j++) o[127-8*j -: 8] = s[j];
      return o;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=no_ready required=ready_within_200", name);
   endtask

   // Cycle-level expectation: sample on start, publish result after the latency
   bit           m_busy = 1'b0;
   logic         m_ready = 1'b0;
   logic [127:0] m_ct = '0;
   logic [127:0] m_pend = '0;
   int           m_cnt = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_busy  <= 1'b0;
         m_ready <= 1'b0;
         m_ct    <= '0;
      end else if (!m_busy) begin
         if (bus.key_len != 3'b000) begin
            m_busy  <= 1'b1;
            m_ready <= 1'b0;
            m_cnt   <= lat_of(nk_of(bus.key_len));
            m_pend  <= aes_model(bus.plaintext, bus.key, nk_of(bus.key_len));
         end
      end else if (m_cnt == 1) begin
         m_busy  <= 1'b0;
         m_ready <= 1'b1;
         m_ct    <= m_pend;
      end else begin
         m_cnt <= m_cnt - 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_ready", {127'b0, bus.ready}, {127'b0, m_ready});
         chk("cyc_ciphertext", bus.ciphertext, m_ct);
      end
   end

   task automatic run_and_wait(input string name, input logic [255:0] k, input logic [2:0] kl,
                               input int exp_lat, input logic [127:0] exp_ct);
      int found = 0;
      @(negedge clk);
      bus.plaintext = PT;
      bus.key       = k;
      bus.key_len   = kl;
      for (int n = 1; n <= 200 && found == 0; n++) begin
         @(negedge clk);
         if (n == 1) bus.key_len = 3'b000;
         if (bus.ready) found = n;
      end
      if (found == 0) timeout({name, "_timeout"});
      else begin
         chk_int({name, "_latency"}, found - 1, exp_lat);
         chk({name, "_ct"}, bus.ciphertext, exp_ct);
      end
   endtask

   initial begin
      int n1, n2;
      logic [7:0] inv, b;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         b = inv;
         sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      end
      chk("sbox_00", {120'b0, sb[0]}, 128'h63);
      chk("sbox_53", {120'b0, sb[83]}, 128'hed);
      chk("model_128", aes_model(PT, K128, 4), CT128);
      chk("model_192", aes_model(PT, K192, 6), CT192);
      chk("model_256", aes_model(PT, K256, 8), CT256);

      bus.plaintext = '0;
      bus.key       = '0;
      bus.key_len   = 3'b000;
      reset         = 1'b1;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      chk("reset_ready", {127'b0, bus.ready}, 128'h0);
      chk("reset_ct", bus.ciphertext, 128'h0);

      // reset held while a start is requested: no run may follow
      bus.plaintext = PT;
      bus.key       = K128;
      bus.key_len   = 3'b001;
      @(negedge clk);
      reset       = 1'b0;
      bus.key_len = 3'b000;
      repeat (100) @(negedge clk);
      chk("idle_ready", {127'b0, bus.ready}, 128'h0);
      chk("idle_ct", bus.ciphertext, 128'h0);

      run_and_wait("aes128", K128, 3'b001, 50, CT128);
      run_and_wait("aes192", K192, 3'b010, 58, CT192);
      run_and_wait("aes256", K256, 3'b101, 66, CT256);

      @(negedge clk);
      bus.key_len = 3'b001;
      bus.key     = K128;
      @(negedge clk);
      bus.key_len = 3'b000;
      repeat (19) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_ready", {127'b0, bus.ready}, 128'h0);
      chk("abort_ct", bus.ciphertext, 128'h0);
      reset = 1'b0;
      run_and_wait("after_abort", K128, 3'b001, 50, CT128);

      // inputs disturbed mid-run, key_len left nonzero to force back-to-back runs
      @(negedge clk);
      bus.plaintext = PT;
      bus.key       = K128;
      bus.key_len   = 3'b001;
      n1 = 0;
      for (int n = 1; n <= 200 && n1 == 0; n++) begin
         @(negedge clk);
         if (n == 10) begin
            bus.plaintext = PT_ALT;
            bus.key       = K_ALT;
            bus.key_len   = 3'b110;
         end
         if (n == 20) bus.key_len = 3'b001;
         if (bus.ready) n1 = n;
      end
      if (n1 == 0) timeout("chg_timeout");
      else begin
         chk_int("chg_latency", n1 - 1, 50);
         chk("chg_ct", bus.ciphertext, CT128);
         n2 = 0;
         for (int n = n1 + 1; n <= n1 + 200 && n2 == 0; n++) begin
            @(negedge clk);
            if (n == n1 + 1) chk("pulse_width", {127'b0, bus.ready}, 128'h0);
            if (bus.ready) n2 = n;
         end
         if (n2 == 0) timeout("repeat_timeout");
         else begin
            chk_int("repeat_period", n2 - n1, 51);
            chk("repeat_ct", bus.ciphertext, aes_model(PT_ALT, K_ALT, 4));
         end
      end
      bus.key_len = 3'b000;
      repeat (5) @(negedge clk);
      chk("final_ready_held", {127'b0, bus.ready}, 128'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
